// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: start, 8 data bits MSB first, parity (even/odd selectable), one stop bit.
// Latency: 2 synchroniser cycles + MID_SAMPLE + 10*CLKS_PER_BIT from line falling edge to rx_valid.
// No backpressure: rx_valid is a one-cycle strobe, consumer must take rx_data when it fires.
//
// Ports:
//   clk_3125      - system clock, all logic on rising edge
//   rst_n         - asynchronous active-low reset
//   parity_type   - 0 = even, 1 = odd; used at the parity sample point
//   rx            - asynchronous serial line, idle high
//   rx_data       - last received byte, held until the next frame completes
//   rx_valid      - one-cycle strobe when rx_data and error flags update
//   parity_error  - parity mismatch on last frame, held
//   framing_error - stop bit sampled low on last frame, held
//   rx_busy       - high whenever the receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 14,
    parameter int MID_SAMPLE   = 7
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       parity_type,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Counter value seen on the edge that is N cycles after it was cleared is N-1.
    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(MID_SAMPLE - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    // Two-flop synchroniser plus one history flop for edge detection.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             perr_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             parity_error_q;
    logic             framing_error_q;
    logic             rx_busy_q;

    logic start_edge;
    logic cnt_last;

    assign start_edge = rx_prev_q & ~rx_s_q;
    assign cnt_last   = (cnt_q == BIT_LAST);

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            perr_q          <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            rx_busy_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    if (start_edge) begin
                        state_q   <= START;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == MID_LAST) begin
                        cnt_q <= '0;
                        // Line back high at mid start bit: treat as noise.
                        if (rx_s_q) begin
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        shift_q <= {shift_q[6:0], rx_s_q};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        // Expected bit is ^byte for even, its inverse for odd.
                        perr_q  <= rx_s_q ^ (^shift_q) ^ parity_type;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        cnt_q           <= '0;
                        rx_data_q       <= shift_q;
                        parity_error_q  <= perr_q;
                        framing_error_q <= ~rx_s_q;
                        rx_valid_q      <= 1'b1;
                        // Leave mid stop bit so a back-to-back start edge is not missed.
                        if (rx_s_q) begin
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state_q <= BREAK_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s_q) begin
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign rx_busy       = rx_busy_q;

endmodule
